// File: rtl/gaussian_blur.sv
`default_nettype none
// ============================================================================
// Module   : gaussian_blur
// Purpose  : 3x3 Gaussian smoothing ([1 2 1; 2 4 2; 1 2 1] / 16) over a
//            raster-order 8-bit grayscale frame. It uses a two-line sliding
//            window shift register and produces one output pixel per input
//            pixel, in raster order. Border pixels are written as 0.
// Ports    : clock      - single clock, all logic on posedge
//            reset      - synchronous, active-low reset
//            in_rd_en   - pop the upstream grayscale FIFO this cycle
//            in_empty   - upstream FIFO empty
//            in_dout    - pixel at the upstream FIFO head
//            out_wr_en  - push a blurred pixel this cycle
//            out_full   - downstream FIFO full
//            out_din    - blurred pixel (0 when out_wr_en is low)
// Config   : GAUSSIAN_ROUND_EN - when defined, the final /16 rounds half-up.
//            When undefined, it truncates.
// Revision : 1.0 - initial release
// ============================================================================
module gaussian_blur #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_rd_en,
    input  logic       in_empty,
    input  logic [7:0] in_dout,
    output logic       out_wr_en,
    input  logic       out_full,
    output logic [7:0] out_din
);

    // The incoming pixel forms window slot 0. Only slots 1..2W+2 need storage,
    // so the register holds 2W+2 entries.
    localparam int c_SR_LEN  = 2 * WIDTH + 2;
    localparam int c_WIN_LEN = 2 * WIDTH + 3;
    localparam int c_PIX     = WIDTH * HEIGHT;
    localparam int c_PIX_W   = $clog2(c_PIX);
    localparam int c_COL_W   = $clog2(WIDTH);
    localparam int c_ROW_W   = $clog2(HEIGHT);
    localparam int c_FLUSH_W = $clog2(WIDTH + 1);

    localparam logic [c_PIX_W-1:0]   c_FILL_LAST  = c_PIX_W'(WIDTH);
    localparam logic [c_PIX_W-1:0]   c_PIX_LAST   = c_PIX_W'(c_PIX - 1);
    localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(WIDTH);
    localparam logic [c_COL_W-1:0]   c_COL_LAST   = c_COL_W'(WIDTH - 1);
    localparam logic [c_ROW_W-1:0]   c_ROW_LAST   = c_ROW_W'(HEIGHT - 1);

    localparam logic [1:0] c_S_FILL  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_FLUSH = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [7:0]           r_sr [c_SR_LEN];
    logic [7:0]           w_win [c_WIN_LEN];
    logic [c_PIX_W-1:0]   r_in_cnt;
    logic [c_FLUSH_W-1:0] r_flush_cnt;
    logic [c_ROW_W-1:0]   r_ctr_row;
    logic [c_COL_W-1:0]   r_ctr_col;
    logic                 r_out_valid;
    logic [7:0]           r_out_reg;

    logic                 w_src_ok;
    logic                 w_adv;
    logic                 w_emit;
    logic [7:0]           w_new_pix;
    logic [11:0]          w_corners;
    logic [11:0]          w_edges;
    logic [11:0]          w_sum;
    logic [7:0]           w_result;
    logic                 w_border;
    logic [7:0]           w_pix_out;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= c_S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_FILL: begin
                if (w_adv && (r_in_cnt == c_FILL_LAST)) begin
                    w_state_next = c_S_RUN;
                end
            end
            c_S_RUN: begin
                if (w_adv && (r_in_cnt == c_PIX_LAST)) begin
                    w_state_next = c_S_FLUSH;
                end
            end
            c_S_FLUSH: begin
                if (w_adv && (r_flush_cnt == c_FLUSH_LAST)) begin
                    w_state_next = c_S_FILL;
                end
            end
            default: w_state_next = c_S_FILL;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs and handshake
    // The reset gating keeps both FIFOs untouched while reset is low.
    // ------------------------------------------------------------------------
    always_comb begin
        w_src_ok  = (r_state == c_S_FLUSH) ? 1'b1 : ~in_empty;
        w_adv     = reset & w_src_ok & (~r_out_valid | ~out_full);
        w_emit    = (r_state == c_S_RUN) || (r_state == c_S_FLUSH);
        in_rd_en  = w_adv & (r_state != c_S_FLUSH);
        out_wr_en = reset & r_out_valid & ~out_full;
        out_din   = out_wr_en ? r_out_reg : 8'h00;
        w_new_pix = (r_state == c_S_FLUSH) ? 8'h00 : in_dout;
    end

    // ------------------------------------------------------------------------
    // Window after this cycle's shift. Slot 0 is the newest pixel and
    // slot W+1 is the centre.
    // ------------------------------------------------------------------------
    always_comb begin
        w_win[0] = w_new_pix;
        for (int i = 1; i < c_WIN_LEN; i++) begin
            w_win[i] = r_sr[i-1];
        end
    end

    always_comb begin
        w_corners = 12'(w_win[0]) + 12'(w_win[2])
                  + 12'(w_win[2*WIDTH]) + 12'(w_win[2*WIDTH+2]);
        w_edges   = 12'(w_win[1]) + 12'(w_win[WIDTH])
                  + 12'(w_win[WIDTH+2]) + 12'(w_win[2*WIDTH+1]);
        // The worst case is 16*255 = 4080, so 12 bits never overflow.
        w_sum     = w_corners + (w_edges << 1) + (12'(w_win[WIDTH+1]) << 2);
`ifdef GAUSSIAN_ROUND_EN
        w_result  = 8'((w_sum + 12'd8) >> 4);
`else
        w_result  = 8'(w_sum >> 4);
`endif
        // On border pixels the window wraps across lines or frames, so those
        // outputs are forced to 0.
        w_border  = (r_ctr_row == '0) || (r_ctr_row == c_ROW_LAST)
                 || (r_ctr_col == '0) || (r_ctr_col == c_COL_LAST);
        w_pix_out = w_border ? 8'h00 : w_result;
    end

    // ------------------------------------------------------------------------
    // Line shift register. Its contents need no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (w_adv) begin
            for (int i = 0; i < c_SR_LEN; i++) begin
                r_sr[i] <= w_win[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Counters and output register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_in_cnt    <= '0;
            r_flush_cnt <= '0;
            r_ctr_row   <= '0;
            r_ctr_col   <= '0;
            r_out_valid <= 1'b0;
            r_out_reg   <= 8'h00;
        end else begin
            if (w_adv) begin
                if (r_state == c_S_FLUSH) begin
                    r_flush_cnt <= (r_flush_cnt == c_FLUSH_LAST) ? '0 : r_flush_cnt + 1'b1;
                end else begin
                    r_in_cnt <= (r_in_cnt == c_PIX_LAST) ? '0 : r_in_cnt + 1'b1;
                end

                if (w_emit) begin
                    if ((r_state == c_S_FLUSH) && (r_flush_cnt == c_FLUSH_LAST)) begin
                        r_ctr_row <= '0;
                        r_ctr_col <= '0;
                    end else if (r_ctr_col == c_COL_LAST) begin
                        r_ctr_col <= '0;
                        r_ctr_row <= r_ctr_row + 1'b1;
                    end else begin
                        r_ctr_col <= r_ctr_col + 1'b1;
                    end
                end
            end

            // There is one output per shift. A shift happens only when the
            // register is empty or drains this same cycle, so data is never lost.
            if (w_adv && w_emit) begin
                r_out_reg   <= w_pix_out;
                r_out_valid <= 1'b1;
            end else if (out_wr_en) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gaussian_blur.sv
`default_nettype none
// ============================================================================
// Module   : tb_gaussian_blur
// Purpose  : Self-checking bench for gaussian_blur (4x4 frames). Upstream and
//            downstream FIFOs are modelled with queues and random throttling.
//            Expected pixels come from a direct 3x3 convolution over the
//            frame image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gaussian_blur;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 4;
    localparam int NPIX   = WIDTH * HEIGHT;

    localparam int K_CONST   = 0;
    localparam int K_IMPULSE = 1;
    localparam int K_RANDOM  = 2;
    localparam int K_RAMP    = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_rd_en;
    logic       in_empty;
    logic [7:0] in_dout;
    logic       out_wr_en;
    logic       out_full;
    logic [7:0] out_din;

    gaussian_blur #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_rd_en  (in_rd_en),
        .in_empty  (in_empty),
        .in_dout   (in_dout),
        .out_wr_en (out_wr_en),
        .out_full  (out_full),
        .out_din   (out_din)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cycle    = 0;
    int         gap_pct  = 0;
    int         full_pct = 0;
    bit         force_full = 1'b0;
    logic       last_rd, last_wr;
    logic [7:0] in_q [$];
    int         got_q [$];
    int         exp_q [$];
    int         wr_cycles [$];
    int         pop_cycles [$];
    int         img [NPIX];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : -1;
    endfunction

    // Reference: direct 3x3 convolution over the stored frame.
    function automatic int blur_ref(input int r, input int c);
        int s = 0;
        if (r == 0 || r == HEIGHT-1 || c == 0 || c == WIDTH-1) return 0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                s += img[(r+dr)*WIDTH + (c+dc)] * ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1);
`ifdef GAUSSIAN_ROUND_EN
        return (s + 8) / 16;
`else
        return s / 16;
`endif
    endfunction

    // Runs one clock cycle. Inputs are driven just after the rising edge and
    // outputs are sampled on the falling edge.
    task automatic step();
        if (!reset) begin
            in_empty = 1'b0;
            in_dout  = 8'($urandom_range(0, 255));
            out_full = 1'b0;
        end else begin
            in_empty = (in_q.size() == 0) || (int'($urandom_range(0, 99)) < gap_pct);
            in_dout  = (in_q.size() != 0) ? in_q[0] : 8'($urandom_range(0, 255));
            out_full = force_full || (int'($urandom_range(0, 99)) < full_pct);
        end
        #4;
        last_rd = in_rd_en;
        last_wr = out_wr_en;
        if (!reset) begin
            check_eq("rst_rd_en", in_rd_en, 0);
            check_eq("rst_wr_en", out_wr_en, 0);
            check_eq("rst_din", out_din, 0);
        end else begin
            check_eq("rd_while_empty", in_rd_en && in_empty, 0);
            check_eq("wr_while_full", out_wr_en && out_full, 0);
            check_eq("din_idle_zero", (!out_wr_en && out_din != 8'h00), 0);
            if (in_rd_en && in_q.size() != 0) begin
                void'(in_q.pop_front());
                pop_cycles.push_back(cycle);
            end
            if (out_wr_en) begin
                got_q.push_back(int'(out_din));
                wr_cycles.push_back(cycle);
            end
        end
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic load_frame(input int kind, input int val);
        for (int p = 0; p < NPIX; p++) begin
            case (kind)
                K_CONST:   img[p] = val;
                K_IMPULSE: img[p] = (p == WIDTH + 1) ? val : 0;
                K_RANDOM:  img[p] = int'($urandom_range(0, 255));
                default:   img[p] = (p * val + 3 * val) & 255;
            endcase
            in_q.push_back(8'(img[p]));
        end
        for (int r = 0; r < HEIGHT; r++)
            for (int c = 0; c < WIDTH; c++)
                exp_q.push_back(blur_ref(r, c));
    endtask

    task automatic clear_sb();
        in_q.delete();
        got_q.delete();
        exp_q.delete();
        wr_cycles.delete();
        pop_cycles.delete();
    endtask

    // Waits for all expected writes, idles a few more cycles to expose
    // duplicates, then compares the write stream in order.
    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            step();
            n++;
        end
        for (int i = 0; i < 8; i++) step();
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s_px%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic run_until_pops(input string tag, input int pops);
        int n = 0;
        while (pop_cycles.size() < pops && n < 300) begin
            step();
            n++;
        end
        check_eq({tag, "_reach_pops"}, pop_cycles.size() >= pops, 1);
    endtask

    initial begin
        int pops0, wrs0;
        reset    = 1'b0;
        in_empty = 1'b1;
        in_dout  = 8'h00;
        out_full = 1'b0;
        @(posedge clock);
        #1;
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("post_reset_wr", last_wr, 0);
        check_eq("post_reset_rd", last_rd, 0);

        // Constant frame, no throttle: exact contents, 1 write/clk, latency.
        gap_pct = 0; full_pct = 0;
        load_frame(K_CONST, 100);
        drain("const", 400);
        check_eq("const_c11", got_at(5), 100);
        check_eq("const_c00", got_at(0), 0);
        check_eq("const_rate", (wr_cycles.size() == NPIX) ? wr_cycles[NPIX-1] - wr_cycles[0] : -1, NPIX - 1);
        check_eq("const_latency", (wr_cycles.size() > 0 && pop_cycles.size() > WIDTH + 1)
                                  ? (wr_cycles[0] >= pop_cycles[WIDTH+1] + 1) : 0, 1);
        clear_sb();

        // Impulse 160 at (1,1).
        load_frame(K_IMPULSE, 160);
        drain("imp160", 400);
        check_eq("imp160_11", got_at(5), 40);
        check_eq("imp160_12", got_at(6), 20);
        check_eq("imp160_21", got_at(9), 20);
        check_eq("imp160_22", got_at(10), 10);
        clear_sb();

        // Impulse 15 at (1,1): the final divide is visible here.
        load_frame(K_IMPULSE, 15);
        drain("imp15", 400);
`ifdef GAUSSIAN_ROUND_EN
        check_eq("imp15_11", got_at(5), 4);
        check_eq("imp15_22", got_at(10), 1);
`else
        check_eq("imp15_11", got_at(5), 3);
        check_eq("imp15_22", got_at(10), 0);
`endif
        clear_sb();

        // Random frames under random throttling on both sides.
        for (int f = 0; f < 3; f++) begin
            gap_pct = 20 + 10 * f; full_pct = 30 - 10 * f;
            load_frame(K_RANDOM, 0);
            drain($sformatf("rand%0d", f), 2000);
            clear_sb();
        end

        // Backpressure: out_full held for 10 cycles mid-frame.
        gap_pct = 25; full_pct = 0;
        load_frame(K_RANDOM, 0);
        run_until_pops("bp", 8);
        force_full = 1'b1;
        pops0 = pop_cycles.size();
        wrs0  = got_q.size();
        for (int i = 0; i < 10; i++) step();
        check_eq("bp_pops_le1", (pop_cycles.size() - pops0) <= 1, 1);
        check_eq("bp_no_writes", got_q.size() - wrs0, 0);
        force_full = 1'b0;
        drain("bp", 2000);
        clear_sb();

        // Reset for one cycle after pixel 7 is accepted, then a clean frame.
        gap_pct = 0; full_pct = 0;
        load_frame(K_RANDOM, 0);
        run_until_pops("mrst", 8);
        reset = 1'b0;
        step();
        clear_sb();
        reset = 1'b1;
        step();
        check_eq("mrst_next_wr", last_wr, 0);
        check_eq("mrst_next_rd", last_rd, 0);
        gap_pct = 20; full_pct = 20;
        load_frame(K_RANDOM, 0);
        drain("mrst_frame", 2000);
        clear_sb();

        // Two back-to-back ramp frames queued at once.
        gap_pct = 0; full_pct = 0;
        load_frame(K_RAMP, 7);
        load_frame(K_RAMP, 13);
        drain("b2b", 800);
        clear_sb();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
